button_reader: RTL and testbench

// - Input-side counterpart to the LED output path: conditions one raw push-button pad.
// - Board: Colorlight 5A-75E, 25 MHz clk. Feeds clean level and event pulses to user logic.
// - Pipeline: 2-FF synchroniser, then debounce FSM, then press / release / long-press pulses

---
 rtl/button_reader_pkg.sv | 14 +
 rtl/button_reader_sync_2ff.sv | 23 ++
 rtl/button_reader.sv | 139 +++++++++++++
 tb/tb_button_reader.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/button_reader_pkg.sv
// rtl/button_reader_pkg.sv - board constants and debounce FSM state encoding for button_reader
package button_reader_pkg;

    localparam int CLK_HZ_DEFAULT = 25_000_000;
    localparam int MS_CYCLES      = CLK_HZ_DEFAULT / 1000;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        HELD       = 2'd2,
        DB_RELEASE = 2'd3
    } btn_state_t;

endpackage

// File: rtl/button_reader_sync_2ff.sv
// rtl/button_reader_sync_2ff.sv - 1-bit two-flop synchroniser with configurable reset value
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_reader.sv
// rtl/button_reader.sv - push-button conditioner: sync, debounce, press/release/long-press pulses, press counter
module button_reader
    import button_reader_pkg::*;
#(
    parameter int CLK_HZ      = CLK_HZ_DEFAULT,
    parameter int DB_CYCLES   = 250_000,
    parameter int LONG_CYCLES = 25_000_000,
    parameter bit ACTIVE_LOW  = 1'b1,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn,
    output logic             btn_level,
    output logic             press,
    output logic             release_pulse,
    output logic             long_press,
    output logic [CNT_W-1:0] press_count
);

    localparam int DB_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int LONG_W = $clog2(LONG_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_SAT  = LONG_W'(LONG_CYCLES);

    if (DB_CYCLES < 2) begin : g_chk_db
        $error("button_reader: DB_CYCLES must be >= 2");
    end
    if (LONG_CYCLES <= DB_CYCLES) begin : g_chk_long
        $error("button_reader: LONG_CYCLES must exceed DB_CYCLES");
    end
    if (CLK_HZ <= 0) begin : g_chk_clk
        $error("button_reader: CLK_HZ must be positive");
    end

    logic              sync_q;
    logic              act;
    btn_state_t        state;
    logic [DB_W-1:0]   db_cnt;
    logic [LONG_W-1:0] long_cnt;
    logic              long_done;
    logic [LONG_W-1:0] long_inc;
    logic              long_hit;

    // Idle level of the pad is loaded at reset so reset release never looks like a press.
    sync_2ff #(
        .RST_VAL (ACTIVE_LOW)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn),
        .q     (sync_q)
    );

    // Polarity-normalised pressed flag; registered so the FSM sees a clean single-fanout source.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act <= 1'b0;
        end else begin
            act <= sync_q ^ ACTIVE_LOW;
        end
    end

    assign long_inc = (long_cnt == LONG_SAT) ? long_cnt : long_cnt + LONG_W'(1);
    assign long_hit = (long_cnt == LONG_LAST) && !long_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            db_cnt        <= '0;
            long_cnt      <= '0;
            long_done     <= 1'b0;
            btn_level     <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
            press_count   <= '0;
        end else begin
            press         <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
            case (state)
                IDLE: begin
                    if (act) begin
                        state  <= DB_PRESS;
                        db_cnt <= '0;
                    end
                end
                DB_PRESS: begin
                    if (!act) begin
                        state <= IDLE;
                    end else if (db_cnt == DB_LAST) begin
                        state       <= HELD;
                        press       <= 1'b1;
                        btn_level   <= 1'b1;
                        press_count <= press_count + CNT_W'(1);
                        long_cnt    <= '0;
                        long_done   <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt + DB_W'(1);
                    end
                end
                HELD: begin
                    if (!act) begin
                        state  <= DB_RELEASE;
                        db_cnt <= '0;
                    end else begin
                        long_cnt <= long_inc;
                        if (long_hit) begin
                            long_press <= 1'b1;
                            long_done  <= 1'b1;
                        end
                    end
                end
                DB_RELEASE: begin
                    // A rejected release counts as a held cycle, so a glitch of N cycles delays long_press by N.
                    if (act) begin
                        state    <= HELD;
                        long_cnt <= long_inc;
                        if (long_hit) begin
                            long_press <= 1'b1;
                            long_done  <= 1'b1;
                        end
                    end else if (db_cnt == DB_LAST) begin
                        state         <= IDLE;
                        release_pulse <= 1'b1;
                        btn_level     <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt + DB_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_button_reader.sv
// tb/tb_button_reader.sv - directed self-checking bench for button_reader
module tb_button_reader;

    localparam int DB   = 8;
    localparam int LONG = 40;
    localparam int CW   = 3;
    localparam int LAT  = DB + 3;

    logic          clk;
    logic          rst_n;
    logic          btn;
    logic          btn_level;
    logic          press;
    logic          release_pulse;
    logic          long_press;
    logic [CW-1:0] press_count;

    int vectors;
    int miscompares;
    int cyc;
    int press_q[$];
    int rel_q[$];
    int long_q[$];
    logic prev_level;

    button_reader #(
        .CLK_HZ      (25_000_000),
        .DB_CYCLES   (DB),
        .LONG_CYCLES (LONG),
        .ACTIVE_LOW  (1'b1),
        .CNT_W       (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn           (btn),
        .btn_level     (btn_level),
        .press         (press),
        .release_pulse (release_pulse),
        .long_press    (long_press),
        .press_count   (press_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (press) press_q.push_back(cyc);
            if (release_pulse) rel_q.push_back(cyc);
            if (long_press) long_q.push_back(cyc);
            if (press || release_pulse || long_press)
                check("pulse_exclusive", int'(press) + int'(release_pulse) + int'(long_press), 1);
            if (btn_level !== prev_level)
                check("level_with_pulse", int'(btn_level ? press : release_pulse), 1);
        end
        prev_level = btn_level;
    end

    function automatic int first(input int q[$]);
        return (q.size() > 0) ? q[0] : -1;
    endfunction

    task automatic clear_q();
        press_q.delete();
        rel_q.delete();
        long_q.delete();
    endtask

    // Drives btn at a falling edge; returns the number of the first rising edge that samples it.
    task automatic set_btn(input logic v, output int t0);
        @(negedge clk);
        btn = v;
        t0  = cyc + 1;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        run(3);
        rst_n = 1'b1;
    endtask

    int t0, t1, tp;

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        prev_level  = 1'b0;
        btn         = 1'b1;
        rst_n       = 1'b0;
        run(3);
        check("rst_level", int'(btn_level), 0);
        check("rst_press", int'(press), 0);
        check("rst_count", int'(press_count), 0);
        rst_n = 1'b1;
        run(10);
        check("idle_no_press", press_q.size(), 0);

        // T1 clean press and long press
        clear_q();
        set_btn(1'b0, t0);
        run(60);
        check("t1_press_n", press_q.size(), 1);
        check("t1_press_at", first(press_q) - t0, LAT);
        check("t1_level", int'(btn_level), 1);
        check("t1_long_n", long_q.size(), 1);
        check("t1_long_at", first(long_q) - first(press_q), LONG);
        check("t1_count", int'(press_count), 1);
        set_btn(1'b1, t1);
        run(20);
        check("t1_rel_n", rel_q.size(), 1);
        check("t1_rel_at", first(rel_q) - t1, LAT);
        check("t1_level_off", int'(btn_level), 0);

        // T2 bounce then settle pressed
        clear_q();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            btn = (i % 2 == 0) ? 1'b0 : 1'b1;
            run(2);
        end
        set_btn(1'b0, t0);
        run(25);
        check("t2_press_n", press_q.size(), 1);
        check("t2_press_at", first(press_q) - t0, LAT);
        check("t2_rel_n", rel_q.size(), 0);
        check("t2_long_n", long_q.size(), 0);
        tp = first(press_q);

        // T3 release glitch of 5 cycles while held
        set_btn(1'b1, t1);
        run(4);
        set_btn(1'b0, t1);
        run(60);
        check("t3_rel_n", rel_q.size(), 0);
        check("t3_level", int'(btn_level), 1);
        check("t3_long_n", long_q.size(), 1);
        check("t3_long_at", first(long_q) - tp, LONG + 5);
        set_btn(1'b1, t1);
        run(20);
        check("t3_rel_after", rel_q.size(), 1);

        // T4 short press
        clear_q();
        set_btn(1'b0, t0);
        run(19);
        set_btn(1'b1, t1);
        run(30);
        check("t4_press_at", first(press_q) - t0, LAT);
        check("t4_rel_at", first(rel_q) - t1, LAT);
        check("t4_long_n", long_q.size(), 0);
        check("t4_level", int'(btn_level), 0);
        check("t4_count", int'(press_count), 3);

        // T5 counter wrap from reset
        do_reset();
        run(5);
        for (int i = 0; i < 9; i++) begin
            set_btn(1'b0, t0);
            run(15);
            check("t5_count", int'(press_count), (i + 1) % 8);
            set_btn(1'b1, t1);
            run(15);
        end

        // T6 async reset while held with long press pending
        clear_q();
        set_btn(1'b0, t0);
        run(30);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_level", int'(btn_level), 0);
        check("t6_rst_count", int'(press_count), 0);
        check("t6_rst_pulses", int'(press) + int'(release_pulse) + int'(long_press), 0);
        run(2);
        @(negedge clk);
        rst_n = 1'b1;
        t0    = cyc + 1;
        clear_q();
        run(20);
        check("t6_press_at", first(press_q) - t0, LAT);
        check("t6_count", int'(press_count), 1);
        check("t6_long_n", long_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
